// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared state encodings and opcode constants for the fetch controller
// and the execute datapath.
package instr_fetch_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_EXEC  = 4'd1,
        ST_FETCH = 4'd2,
        ST_HALT  = 4'd15
    } state_t;

    localparam logic [7:0] OP_LIMM16 = 8'h02;
    localparam logic [7:0] OP_CP     = 8'hD2;
    localparam logic [7:0] OP_CPDR   = 8'hD3;
    localparam logic [7:0] OP_ADD    = 8'h14;
    localparam logic [7:0] OP_SUB    = 8'h15;
    localparam logic [7:0] OP_END    = 8'hFF;

endpackage

// File: rtl/instr_fetch_ctrl_decode_we.sv
// Opcode decoder: register write enable, CPDR and END flags.
// Purely combinational so the datapath can reuse it.
module instr_decode_we
    import instr_fetch_ctrl_pkg::*;
(
    input  logic [7:0] op,
    output logic       we,
    output logic       is_cpdr,
    output logic       is_end
);

    always_comb begin
        we      = 1'b0;
        is_cpdr = 1'b0;
        is_end  = 1'b0;
        unique case (op)
            OP_LIMM16,
            OP_CP,
            OP_ADD,
            OP_SUB:  we      = 1'b1;
            OP_CPDR: is_cpdr = 1'b1;
            OP_END:  is_end  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch/sequencing controller: fetches words over a req/ack
// handshake and steps IDLE -> FETCH -> EXEC until END halts it.
module instr_fetch_ctrl
    import instr_fetch_ctrl_pkg::*;
#(
    parameter int          PC_WIDTH = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [31:0]         imem_data,
    output logic [31:0]         instr0,
    output logic [3:0]          current_state,
    output logic [PC_WIDTH-1:0] pc,
    output logic                ireg_we,
    input  logic [31:0]         ireg_d0,
    output logic [31:0]         dbg_out,
    output logic                dbg_valid,
    output logic                halted
);

    localparam logic [PC_WIDTH-1:0] PC_INIT = PC_WIDTH'(RESET_PC);

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]         instr0_q, instr0_d;
    logic [31:0]         dbg_out_q, dbg_out_d;
    logic                dbg_valid_q, dbg_valid_d;

    logic dec_we;
    logic dec_cpdr;
    logic dec_end;

    instr_decode_we u_dec (
        .op      (instr0_q[31:24]),
        .we      (dec_we),
        .is_cpdr (dec_cpdr),
        .is_end  (dec_end)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= PC_INIT;
            instr0_q    <= '0;
            dbg_out_q   <= '0;
            dbg_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr0_q    <= instr0_d;
            dbg_out_q   <= dbg_out_d;
            dbg_valid_q <= dbg_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr0_d    = instr0_q;
        dbg_out_d   = dbg_out_q;
        dbg_valid_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    instr0_d = imem_data;
                    pc_d     = pc_q + PC_WIDTH'(1);
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // register read data is valid throughout EXEC
                if (dec_cpdr) begin
                    dbg_out_d   = ireg_d0;
                    dbg_valid_d = 1'b1;
                end
                state_d = dec_end ? ST_HALT : ST_FETCH;
            end
            ST_HALT: begin
                if (start) begin
                    pc_d    = PC_INIT;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign imem_req      = (state_q == ST_FETCH);
    assign imem_addr     = pc_q;
    assign instr0        = instr0_q;
    assign current_state = state_q;
    assign pc            = pc_q;
    assign ireg_we       = (state_q == ST_EXEC) && dec_we;
    assign dbg_out       = dbg_out_q;
    assign dbg_valid     = dbg_valid_q;
    assign halted        = (state_q == ST_HALT);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Randomized scoreboard bench for instr_fetch_ctrl with a transaction-level
// program model (PC_WIDTH=4 so address wrap is exercised).
module tb_instr_fetch_ctrl;

    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          imem_req;
    logic [PW-1:0] imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_data;
    logic [31:0]   instr0;
    logic [3:0]    current_state;
    logic [PW-1:0] pc;
    logic          ireg_we;
    logic [31:0]   ireg_d0;
    logic [31:0]   dbg_out;
    logic          dbg_valid;
    logic          halted;

    instr_fetch_ctrl #(.PC_WIDTH(PW), .RESET_PC(0)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_data     (imem_data),
        .instr0        (instr0),
        .current_state (current_state),
        .pc            (pc),
        .ireg_we       (ireg_we),
        .ireg_d0       (ireg_d0),
        .dbg_out       (dbg_out),
        .dbg_valid     (dbg_valid),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] instr;
        logic [3:0]  pc;
        logic        we;
    } exec_t;

    typedef struct {
        int          cyc;
        logic [31:0] val;
    } evt_t;

    exec_t exq[$];
    evt_t  dq[$];
    evt_t  hq[$];

    logic [31:0] mem [16];
    int          checks = 0;
    int          errors = 0;
    int          c = 0;
    bit          active = 0;

    // model: 0 idle, 1 running, 2 halt pending, 3 halted
    int         m_mode;
    logic [3:0] m_pc;
    int         m_req_from;
    int         m_halt_at;
    int         wcnt;
    int         max_wait;
    bit         hold;

    always @(posedge clk) c <= c + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d act=%h exp=%h", nm, c, act, exp);
        end
    endtask

    function automatic bit op_we(logic [7:0] op);
        return op inside {8'h02, 8'hD2, 8'h14, 8'h15};
    endfunction

    function automatic logic [31:0] rnd_instr(bit allow_end);
        logic [31:0] t;
        logic [7:0]  op;
        t = $urandom;
        case ($urandom_range(0, 7))
            0: op = 8'h02;
            1: op = 8'hD2;
            2: op = 8'hD3;
            3: op = 8'h14;
            4: op = 8'h15;
            5: op = 8'h00;
            6: op = allow_end ? 8'hFF : 8'hD3;
            default: op = t[31:24];
        endcase
        if (!allow_end && op == 8'hFF) op = 8'h33;
        return {op, t[23:0]};
    endfunction

    // memory responder + program-level reference model
    always @(negedge clk) begin
        if (active) begin
            bit exp_req;
            logic [7:0] op;
            if (m_mode == 2 && c >= m_halt_at) m_mode = 3;
            exp_req = (m_mode == 1) && (c >= m_req_from);
            chk("imem_req", imem_req, exp_req);
            if (exp_req) chk("imem_addr", imem_addr, m_pc);
            start = ($urandom_range(0, 3) == 0);
            if (hold) hold = 0;
            else ireg_d0 = $urandom;
            if (exp_req && wcnt == 0) begin
                imem_ack  = 1'b1;
                imem_data = mem[m_pc];
                op = imem_data[31:24];
                if (max_wait == 0) ireg_d0 = 32'hDEADBEEF;
                hold = 1;
                exq.push_back('{c + 1, imem_data, m_pc + 4'd1, op_we(op)});
                if (op == 8'hD3) dq.push_back('{c + 2, ireg_d0});
                m_pc = m_pc + 4'd1;
                if (op == 8'hFF) begin
                    m_mode    = 2;
                    m_halt_at = c + 2;
                    hq.push_back('{c + 2, 32'(m_pc)});
                end else begin
                    m_req_from = c + 2;
                end
                wcnt = $urandom_range(0, max_wait);
            end else if (exp_req) begin
                imem_ack  = 1'b0;
                imem_data = $urandom;
                wcnt--;
            end else begin
                imem_ack  = 1'($urandom_range(0, 1));
                imem_data = $urandom;
                if ((m_mode == 0 || m_mode == 3) && start) begin
                    if (m_mode == 3) m_pc = 4'd0;
                    m_mode     = 1;
                    m_req_from = c + 1;
                end
            end
        end
    end

    // monitor: compares DUT outputs against queued expectations
    always @(negedge clk) begin
        if (active) begin
            if (exq.size() > 0 && exq[0].cyc <= c) begin
                exec_t e;
                e = exq.pop_front();
                chk("exec_cycle", 32'(e.cyc), 32'(c));
                chk("exec_state", current_state, 4'd1);
                chk("exec_instr0", instr0, e.instr);
                chk("exec_pc", pc, e.pc);
                chk("exec_we", ireg_we, e.we);
            end else begin
                chk("spurious_exec", current_state == 4'd1, 1'b0);
                chk("we_outside_exec", ireg_we, 1'b0);
            end
            if (dq.size() > 0 && dq[0].cyc <= c) begin
                evt_t d;
                d = dq.pop_front();
                chk("dbg_valid", dbg_valid, 1'b1);
                chk("dbg_out", dbg_out, d.val);
            end else begin
                chk("dbg_valid_idle", dbg_valid, 1'b0);
            end
            if (hq.size() > 0 && hq[0].cyc <= c) begin
                evt_t h;
                h = hq.pop_front();
                chk("halt_state", current_state, 4'd15);
                chk("halted", halted, 1'b1);
                chk("halt_pc", pc, h.val);
            end
        end
    end

    initial begin
        bit found;
        reset     = 1'b1;
        start     = 1'b0;
        imem_ack  = 1'b0;
        imem_data = '0;
        ireg_d0   = '0;
        hold      = 0;
        wcnt      = 0;
        max_wait  = 0;
        m_mode    = 0;
        m_pc      = '0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_state", current_state, 4'd0);
        chk("rst_pc", pc, 4'd0);
        chk("rst_instr0", instr0, 32'h0);
        chk("rst_dbg_out", dbg_out, 32'h0);
        chk("rst_dbg_valid", dbg_valid, 1'b0);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_we", ireg_we, 1'b0);
        chk("rst_halted", halted, 1'b0);

        mem[0] = 32'h02040005;
        mem[1] = 32'hD3001000;
        mem[2] = 32'h14000000;
        mem[3] = 32'hFF000000;
        reset  = 1'b0;
        active = 1;
        repeat (80) @(negedge clk);

        max_wait = 3;
        repeat (80) @(negedge clk);

        for (int i = 0; i < 16; i++) mem[i] = rnd_instr(1);
        repeat (1500) @(negedge clk);

        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            #1;
            if (imem_req && !imem_ack) found = 1;
        end
        chk("fetch_wait_found", found, 1'b1);
        active = 0;
        reset  = 1'b1;
        #1;
        chk("midrst_req", imem_req, 1'b0);
        chk("midrst_state", current_state, 4'd0);
        chk("midrst_pc", pc, 4'd0);
        chk("midrst_instr0", instr0, 32'h0);
        chk("midrst_dbg_out", dbg_out, 32'h0);
        chk("midrst_halted", halted, 1'b0);
        imem_ack  = 1'b1;
        imem_data = 32'h02FFFFFF;
        start     = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("late_ack_state", current_state, 4'd0);
        chk("late_ack_req", imem_req, 1'b0);
        chk("late_ack_instr0", instr0, 32'h0);
        chk("late_ack_pc", pc, 4'd0);
        exq.delete();
        dq.delete();
        hq.delete();
        m_mode   = 0;
        m_pc     = '0;
        wcnt     = 0;
        hold     = 0;
        imem_ack = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = rnd_instr(0);
        active = 1;
        repeat (600) @(negedge clk);

        active = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
